mme_issue_ctrl: RTL and testbench

In-order issue controller between the instruction decoder and the multimedia ALU pipeline. Holds one decoded instruction, checks its source registers against a per-register pending-write scoreboard, and releases it to the ALU only when no read-after-write hazard remains. It applies back-pressure to the decoder while stalled and counts stall cycles for performance monitoring.

---
 rtl/mme_pkg.sv | 25 ++
 rtl/mme_scoreboard.sv | 52 +++++
 rtl/mme_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_mme_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mme_pkg.sv
// Shared types for the multimedia issue controller.
// Optional ALU bypass forwarding is enabled by defining MME_FWD_EN.
package mme_pkg;

   localparam int REG_W      = 5;
   localparam int ALU_CTRL_W = 8;
   localparam int IMM_W      = 16;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [REG_W-1:0]      rd;
      logic [REG_W-1:0]      rs1;
      logic [REG_W-1:0]      rs2;
      logic [REG_W-1:0]      rs3;
      logic                  use_imm;
      logic [IMM_W-1:0]      imm;
      logic                  wb;
   } mme_dec_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } mme_state_t;

endpackage

// File: rtl/mme_scoreboard.sv
// Per-register pending-write down-counters with three source read ports.
// fwd_ok marks sources whose write lands on the next edge.
module mme_scoreboard
   import mme_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int WB_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld,
   input  logic [REG_W-1:0]      ld_rd,
   input  logic [2:0][REG_W-1:0] rs,
   output logic [2:0]            pending,
   output logic [2:0]            fwd_ok,
   output logic                  any_pend
);

   localparam logic [2:0] LD_VAL = 3'(WB_LATENCY - 1);

   logic [2:0] cnt [NUM_REGS];

   // A load on the same edge as a decrement wins; r0 never loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ld && (i > 0) && (ld_rd == REG_W'(i)))
               cnt[i] <= LD_VAL;
            else if (cnt[i] != '0)
               cnt[i] <= cnt[i] - 3'd1;
         end
      end
   end

   always_comb begin
      pending = '0;
      fwd_ok  = '0;
      for (int s = 0; s < 3; s++) begin
         pending[s] = (rs[s] != '0) && (cnt[rs[s]] != '0);
         fwd_ok[s]  = pending[s] && (cnt[rs[s]] == 3'd1);
      end
   end

   always_comb begin
      any_pend = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         any_pend = any_pend | (cnt[i] != '0);
   end

endmodule

// File: rtl/mme_issue_ctrl.sv
// In-order single-entry issue stage with RAW scoreboard and stall counter.
// Define MME_FWD_EN to let cnt==1 sources issue through the ALU bypass.
module mme_issue_ctrl
   import mme_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int WB_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_CTRL_W-1:0] in_alu_ctrl,
   input  logic [REG_W-1:0]      in_rd,
   input  logic [REG_W-1:0]      in_rs1,
   input  logic [REG_W-1:0]      in_rs2,
   input  logic [REG_W-1:0]      in_rs3,
   input  logic                  in_use_imm,
   input  logic [IMM_W-1:0]      in_imm,
   input  logic                  in_wb,
   input  logic                  flush,
   output logic                  iss_valid,
   output logic [ALU_CTRL_W-1:0] iss_alu_ctrl,
   output logic [REG_W-1:0]      iss_rd,
   output logic [REG_W-1:0]      iss_rs1,
   output logic [REG_W-1:0]      iss_rs2,
   output logic [REG_W-1:0]      iss_rs3,
   output logic                  iss_use_imm,
   output logic [IMM_W-1:0]      iss_imm,
   output logic                  iss_wb,
`ifdef MME_FWD_EN
   output logic [2:0]            iss_fwd,
`endif
   output logic                  busy,
   output logic [15:0]           stall_cnt
);

`ifdef MME_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   mme_state_t state_q, state_d;
   mme_dec_t   in_dec, hold_q, iss_q;
   logic       hold_v, hazard, issue, accept;
   logic       any_pend;
   logic [2:0] pending, fwd_ok, blocked;
   logic [2:0][REG_W-1:0] src;

   assign in_dec = '{
      alu_ctrl: in_alu_ctrl,
      rd:       in_rd,
      rs1:      in_rs1,
      rs2:      in_rs2,
      rs3:      in_rs3,
      use_imm:  in_use_imm,
      imm:      in_imm,
      wb:       in_wb
   };

   assign hold_v   = (state_q == ST_HELD);
   assign src      = {hold_q.rs3, hold_q.rs2, hold_q.rs1};
   assign blocked  = pending & ~(fwd_ok & {3{FWD}});
   assign hazard   = hold_v && (blocked != '0);
   assign issue    = hold_v && !hazard && !flush;
   assign in_ready = rst_n && !flush && (!hold_v || issue);
   assign accept   = in_valid && in_ready;
   assign busy     = hold_v || any_pend;

   mme_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .WB_LATENCY (WB_LATENCY)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld       (issue && hold_q.wb && (hold_q.rd != '0)),
      .ld_rd    (hold_q.rd),
      .rs       (src),
      .pending  (pending),
      .fwd_ok   (fwd_ok),
      .any_pend (any_pend)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (accept) state_d = ST_HELD;
         ST_HELD: begin
            if (flush)                 state_d = ST_EMPTY;
            else if (issue && !accept) state_d = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hold_q <= '0;
      else if (accept) hold_q <= in_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid <= 1'b0;
         iss_q     <= '0;
      end else begin
         iss_valid <= issue;
         if (issue) iss_q <= hold_q;
      end
   end

`ifdef MME_FWD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     iss_fwd <= '0;
      else if (issue) iss_fwd <= pending & fwd_ok;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (hazard && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign iss_alu_ctrl = iss_q.alu_ctrl;
   assign iss_rd       = iss_q.rd;
   assign iss_rs1      = iss_q.rs1;
   assign iss_rs2      = iss_q.rs2;
   assign iss_rs3      = iss_q.rs3;
   assign iss_use_imm  = iss_q.use_imm;
   assign iss_imm      = iss_q.imm;
   assign iss_wb       = iss_q.wb;

endmodule

// File: tb/tb_mme_issue_ctrl.sv
// Bench for mme_issue_ctrl: timing model in absolute edge numbers,
// expected issues queued by the driver and popped by a monitor.
module tb_mme_issue_ctrl;
   import mme_pkg::*;

   localparam int NR = 32;
   localparam int WB = 3;
`ifdef MME_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic flush = 1'b0;
   logic in_ready;
   mme_dec_t din = '0;
   logic iss_valid, iss_use_imm, iss_wb, busy;
   logic [ALU_CTRL_W-1:0] iss_alu_ctrl;
   logic [REG_W-1:0] iss_rd, iss_rs1, iss_rs2, iss_rs3;
   logic [IMM_W-1:0] iss_imm;
   logic [15:0] stall_cnt;
`ifdef MME_FWD_EN
   logic [2:0] iss_fwd;
`endif

   mme_issue_ctrl #(.NUM_REGS(NR), .WB_LATENCY(WB)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_ctrl(din.alu_ctrl), .in_rd(din.rd),
      .in_rs1(din.rs1), .in_rs2(din.rs2), .in_rs3(din.rs3),
      .in_use_imm(din.use_imm), .in_imm(din.imm), .in_wb(din.wb),
      .flush(flush),
      .iss_valid(iss_valid), .iss_alu_ctrl(iss_alu_ctrl),
      .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rs3(iss_rs3), .iss_use_imm(iss_use_imm),
      .iss_imm(iss_imm), .iss_wb(iss_wb),
`ifdef MME_FWD_EN
      .iss_fwd(iss_fwd),
`endif
      .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      mme_dec_t   d;
      int         at;
      logic [2:0] fwd;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int edge_n = 0;

   // Model: edge at which each register's write has fully retired.
   bit         m_held;
   mme_dec_t   m_hd;
   int         m_dep_at, m_iss_at;
   logic [2:0] m_fwd;
   int         m_wdone [NR];
   int         m_stall;

   always @(posedge clk) edge_n++;

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   function automatic int rdy(input logic [REG_W-1:0] r);
      if (r == '0) return 0;
      return FWD ? m_wdone[r] : m_wdone[r] + 1;
   endfunction

   function automatic bit m_busy(input int j);
      if (m_held) return 1'b1;
      for (int r = 1; r < NR; r++)
         if (m_wdone[r] > j) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_reset();
      m_held = 0;
      m_stall = 0;
      for (int r = 0; r < NR; r++) m_wdone[r] = 0;
      q.delete();
   endtask

   task automatic step(input logic v, input mme_dec_t d,
                       input logic fl, output logic acc);
      int k;
      logic er, iss_now;
      exp_t e;
      logic [REG_W-1:0] s [3];
      @(negedge clk);
      in_valid = v;
      flush = fl;
      din = d;
      #1;
      k = edge_n + 1;
      iss_now = m_held && !fl && (m_iss_at == k);
      er = !fl && (!m_held || iss_now);
      chk("in_ready", in_ready, er);
      chk("busy", busy, m_busy(edge_n));
      chk("stall_cnt", stall_cnt, m_stall);
      if (m_held && k < m_dep_at && m_stall < 65535) m_stall++;
      if (iss_now) begin
         e.d = m_hd; e.at = k; e.fwd = m_fwd;
         q.push_back(e);
         if (m_hd.wb && m_hd.rd != '0) m_wdone[m_hd.rd] = k + WB - 1;
      end
      if (fl || iss_now) m_held = 0;
      acc = v && er;
      if (acc) begin
         m_held = 1;
         m_hd = d;
         s[0] = d.rs1; s[1] = d.rs2; s[2] = d.rs3;
         m_dep_at = 0;
         for (int i = 0; i < 3; i++)
            if (rdy(s[i]) > m_dep_at) m_dep_at = rdy(s[i]);
         m_iss_at = (m_dep_at > k + 1) ? m_dep_at : k + 1;
         for (int i = 0; i < 3; i++)
            m_fwd[i] = FWD && s[i] != '0 && m_wdone[s[i]] == m_iss_at;
      end
   endtask

   task automatic send(input mme_dec_t d, input int flush_pct);
      logic acc;
      int n;
      acc = 0;
      n = 0;
      while (!acc && n < 40) begin
         step(1'b1, d, ($urandom_range(0, 99) < flush_pct), acc);
         n++;
      end
      if (!acc) chk("send_accept_timeout", 0, 1);
   endtask

   task automatic idle(input logic fl);
      logic acc;
      step(1'b0, '0, fl, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_held || q.size() != 0 || m_busy(edge_n)) && n < 30) begin
         idle(1'b0);
         n++;
      end
      idle(1'b0);
      chk("drain_queue", q.size(), 0);
   endtask

   function automatic mme_dec_t mk(input int rd, input int r1, input int r2,
                                   input int r3, input bit wb);
      mme_dec_t d;
      d.alu_ctrl = 8'($urandom);
      d.rd = REG_W'(rd);
      d.rs1 = REG_W'(r1);
      d.rs2 = REG_W'(r2);
      d.rs3 = REG_W'(r3);
      d.use_imm = 1'b0;
      d.imm = 16'($urandom);
      d.wb = wb;
      return d;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      mme_dec_t g;
      #1;
      if (rst_n) begin
         if (iss_valid) begin
            if (q.size() == 0) begin
               chk("spurious_issue", 1, 0);
            end else begin
               e = q.pop_front();
               g = {iss_alu_ctrl, iss_rd, iss_rs1, iss_rs2, iss_rs3,
                    iss_use_imm, iss_imm, iss_wb};
               chk("iss_edge", edge_n, e.at);
               chk("iss_fields", g, e.d);
`ifdef MME_FWD_EN
               chk("iss_fwd", iss_fwd, e.fwd);
`endif
            end
         end else if (q.size() != 0 && q[0].at <= edge_n) begin
            chk("missing_issue", edge_n, q[0].at);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      mme_dec_t d;
      m_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs",
          {iss_valid, in_ready, busy, stall_cnt, iss_rd, iss_alu_ctrl}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // independent stream
      s0 = m_stall;
      for (int i = 1; i <= 4; i++) send(mk(i, 9 + i, 0, 0, 1'b1), 0);
      drain();
      chk("indep_stall", stall_cnt - 16'(s0), 0);

      // RAW on rs2
      s0 = m_stall;
      send(mk(5, 10, 0, 0, 1'b1), 0);
      send(mk(6, 11, 5, 0, 1'b1), 0);
      drain();
      chk("raw_stall", stall_cnt - 16'(s0), FWD ? 1 : 2);

      // r0 destination and non-writing producer
      s0 = m_stall;
      send(mk(0, 10, 0, 0, 1'b1), 0);
      send(mk(8, 0, 0, 0, 1'b1), 0);
      send(mk(7, 11, 0, 0, 1'b0), 0);
      send(mk(9, 7, 0, 0, 1'b1), 0);
      drain();
      chk("r0_nowb_stall", stall_cnt - 16'(s0), 0);
      chk("r0_nowb_busy", busy, 0);

      // flush while the dependent waits
      send(mk(5, 10, 0, 0, 1'b1), 0);
      send(mk(6, 11, 5, 0, 1'b1), 0);
      idle(1'b1);
      send(mk(12, 13, 0, 0, 1'b1), 0);
      drain();

      // reset with an instruction held and cnt[5]=2
      send(mk(5, 10, 0, 0, 1'b1), 0);
      send(mk(6, 5, 0, 0, 1'b1), 0);
      @(negedge clk);
      #2;
      chk("pre_reset_busy", busy, 1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs",
          {iss_valid, in_ready, busy, stall_cnt, iss_rd, iss_wb}, 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(mk(6, 5, 0, 0, 1'b1), 0);
      drain();
      chk("post_reset_stall", stall_cnt, 0);

      // randomized traffic with occasional flushes and gaps
      for (int n = 0; n < 300; n++) begin
         d = mk($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 4) == 0) begin
            d.use_imm = 1'b1;
            d.rs1 = d.rd;
            d.rs2 = '0;
            d.rs3 = '0;
         end
         send(d, 6);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3) == 0);
      end
      drain();
      chk("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
